// File: rtl/aac_driver.sv
// aac_driver: feeds AAC from a product stream and returns one dot-product result per vector
module aac_driver #(
  parameter int DW      = 16,
  parameter int AW      = 24,
  parameter int MAX_LEN = 128
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          start,
  input  logic [7:0]    len,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  output logic          aac,
  output logic [AW-1:0] a_o,
  input  logic [AW-1:0] acc_in,
  output logic          res_valid,
  input  logic          res_ready,
  output logic [AW-1:0] res_data,
  output logic          busy
);
  typedef enum logic [1:0] {IDLE, FEED, DRAIN, RESULT} state_t;
  localparam logic [7:0] ML = 8'(MAX_LEN);
  state_t        state_q, state_d;
  logic [7:0]    cnt_q, cnt_d, len_q, len_d;
  logic          drn_q, drn_d, aac_q, aac_d, rv_q, rv_d;
  logic [AW-1:0] a_q, a_d, rd_q, rd_d;
  logic          take, last;
  assign in_ready  = state_q == FEED;
  assign busy      = state_q != IDLE;
  assign aac       = aac_q;
  assign a_o       = a_q;
  assign res_valid = rv_q;
  assign res_data  = rd_q;
  assign take      = in_valid & in_ready;
  assign last      = take && cnt_q == len_q - 8'd1;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      len_q   <= '0;
      drn_q   <= 1'b0;
      aac_q   <= 1'b0;
      a_q     <= '0;
      rv_q    <= 1'b0;
      rd_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      drn_q   <= drn_d;
      aac_q   <= aac_d;
      a_q     <= a_d;
      rv_q    <= rv_d;
      rd_q    <= rd_d;
    end
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = start ? FEED : IDLE;
      FEED:    state_d = last ? DRAIN : FEED;
      DRAIN:   state_d = drn_q ? RESULT : DRAIN;
      default: state_d = res_ready ? IDLE : RESULT;
    endcase
  end
  // AAC.out settles one edge after a_o, so DRAIN spends two edges before capturing it
  always_comb begin
    cnt_d = cnt_q;
    len_d = len_q;
    drn_d = 1'b0;
    aac_d = 1'b0;
    a_d   = '0;
    rv_d  = rv_q;
    rd_d  = rd_q;
    case (state_q)
      IDLE: begin
        cnt_d = start ? 8'd0 : cnt_q;
        len_d = !start ? len_q : (len == 8'd0 || len > ML) ? ML : len;
      end
      FEED: begin
        a_d   = take ? {{(AW-DW){in_data[DW-1]}}, in_data} : '0;
        aac_d = cnt_q != 8'd0;
        cnt_d = cnt_q + {7'd0, take};
      end
      DRAIN: begin
        aac_d = 1'b1;
        drn_d = !drn_q;
        rv_d  = drn_q | rv_q;
        rd_d  = drn_q ? acc_in : rd_q;
      end
      default: rv_d = !res_ready;
    endcase
  end
endmodule

// File: tb/tb_aac_driver.sv
// tb_aac_driver: directed scoreboard bench for aac_driver with a behavioural AAC model
module tb_aac_driver;
  logic        clk = 1'b0, reset_n = 1'b0, start = 1'b0, in_valid = 1'b0, res_ready = 1'b0;
  logic [7:0]  len = 8'd0;
  logic [15:0] in_data = 16'd0;
  logic        in_ready, aac, res_valid, busy;
  logic [23:0] a_o, acc_in, res_data;
  int          tests = 0, fails = 0;
  int          vd[128];
  logic [23:0] q[$];
  always #5 clk = ~clk;
  aac_driver dut (
    .clk(clk), .reset_n(reset_n), .start(start), .len(len),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .aac(aac), .a_o(a_o), .acc_in(acc_in),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .busy(busy)
  );
  // AAC: input registered on the edge, sum visible right after it
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) acc_in <= '0;
    else acc_in <= aac ? acc_in + a_o : a_o;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic start_vec(input logic [7:0] l);
    start = 1'b1;
    len = l;
    @(negedge clk);
    start = 1'b0;
  endtask
  task automatic send(input int d);
    int t = 0;
    in_valid = 1'b1;
    in_data = d[15:0];
    while (!in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk("send_timeout", {31'd0, t < 50}, 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask
  task automatic push_exp(input int n);
    int s = 0;
    for (int i = 0; i < n; i++) s += vd[i];
    q.push_back(s[23:0]);
  endtask
  task automatic get_res(input int lat0, input int hold, input bit stray);
    int lat = lat0;
    logic [23:0] held, e;
    while (!res_valid && lat < 400) begin
      @(negedge clk);
      lat++;
    end
    chk("latency", lat, 2);
    held = res_data;
    e = q.size() != 0 ? q.pop_front() : 24'hx;
    chk("res_data", {8'd0, res_data}, {8'd0, e});
    for (int i = 0; i < hold; i++) begin
      start = stray && i == 2;
      len = 8'd1;
      @(negedge clk);
      chk("hold_data", {8'd0, res_data}, {8'd0, held});
      chk("hold_valid", {31'd0, res_valid}, 32'd1);
    end
    start = stray;
    res_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    res_ready = 1'b0;
    chk("released", {31'd0, res_valid}, 32'd0);
    chk("idle", {31'd0, busy}, 32'd0);
  endtask
  task automatic run_vec(input int n, input logic [7:0] l, input int gap, input bit stray);
    push_exp(n);
    start_vec(l);
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, gap)) @(negedge clk);
      if (stray && i == 0) begin
        start = 1'b1;
        len = 8'd1;
      end
      send(vd[i]);
      start = 1'b0;
    end
    get_res(0, 0, 1'b0);
  endtask
  initial begin
    repeat (2) @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_res_valid", {31'd0, res_valid}, 32'd0);
    chk("rst_a_o", {8'd0, a_o}, 32'd0);
    reset_n = 1'b1;
    @(negedge clk);
    // len=1 with in_valid already high in IDLE
    in_valid = 1'b1;
    in_data = 16'd5;
    @(negedge clk);
    chk("idle_no_accept_a", {8'd0, a_o}, 32'd0);
    chk("idle_in_ready", {31'd0, in_ready}, 32'd0);
    vd[0] = 5;
    push_exp(1);
    start_vec(8'd1);
    send(5);
    chk("len1_aac", {31'd0, aac}, 32'd0);
    chk("len1_a_o", {8'd0, a_o}, 32'd5);
    chk("len1_in_ready", {31'd0, in_ready}, 32'd0);
    @(negedge clk);
    chk("drain_aac", {31'd0, aac}, 32'd1);
    chk("drain_a_o", {8'd0, a_o}, 32'd0);
    get_res(1, 0, 1'b0);
    // len=4 back-to-back, stray start during FEED
    vd[0] = 1000; vd[1] = -3000; vd[2] = 7; vd[3] = -1;
    run_vec(4, 8'd4, 0, 1'b1);
    for (int i = 0; i < 128; i++) vd[i] = 32767;
    run_vec(128, 8'd128, 0, 1'b0);
    for (int i = 0; i < 128; i++) vd[i] = -32768;
    run_vec(128, 8'd0, 0, 1'b0);
    vd[0] = 4095; vd[1] = 1; vd[2] = -1;
    run_vec(3, 8'd3, 3, 1'b0);
    // two vectors with held result and a stray start in RESULT
    vd[0] = 3; vd[1] = 4;
    push_exp(2);
    start_vec(8'd2);
    send(3);
    send(4);
    get_res(0, 5, 1'b1);
    vd[0] = 10; vd[1] = -20;
    run_vec(2, 8'd2, 0, 1'b0);
    // reset mid-vector
    start_vec(8'd8);
    send(7);
    send(8);
    send(9);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("mid_rst_aac", {31'd0, aac}, 32'd0);
    chk("mid_rst_a_o", {8'd0, a_o}, 32'd0);
    chk("mid_rst_res_valid", {31'd0, res_valid}, 32'd0);
    chk("mid_rst_res_data", {8'd0, res_data}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    vd[0] = 1; vd[1] = 2;
    run_vec(2, 8'd2, 0, 1'b0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
